// File: rtl/pixel_row_streamer.sv
// Row readout streamer: captures one pixel row, then emits it as fixed-width beats on a
// valid/ready stream with optional un-inversion and Gray decode, plus row/frame flags.
module pixel_row_streamer #(
  parameter int BIT_DEPTH              = 8,
  parameter int WIDTH                  = 4,
  parameter int OUTPUT_BUS_PIXEL_WIDTH = 2,
  parameter int HEIGHT                 = 2
) (
  input  logic                                    CLK,
  input  logic                                    RESET,
  input  logic [WIDTH*BIT_DEPTH-1:0]              ROW_DATA,
  input  logic                                    ROW_VALID,
  output logic                                    ROW_READY,
  input  logic                                    INVERT_EN,
  input  logic                                    GRAY_EN,
  output logic [OUTPUT_BUS_PIXEL_WIDTH*BIT_DEPTH-1:0] OUT_DATA,
  output logic                                    OUT_VALID,
  input  logic                                    OUT_READY,
  output logic                                    OUT_LAST,
  output logic                                    OUT_SOF,
  output logic                                    OUT_EOF,
  output logic [$clog2(HEIGHT+1)-1:0]             ROW_COUNT
);

  localparam int P      = OUTPUT_BUS_PIXEL_WIDTH;
  localparam int BEATS  = WIDTH / P;
  localparam int BUS_W  = P * BIT_DEPTH;
  localparam int ROW_W  = WIDTH * BIT_DEPTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RC_W   = $clog2(HEIGHT + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [RC_W-1:0]   LAST_ROW  = RC_W'(HEIGHT - 1);

  if (WIDTH % OUTPUT_BUS_PIXEL_WIDTH != 0) begin : g_width_check
    $error("WIDTH must be a multiple of OUTPUT_BUS_PIXEL_WIDTH");
  end
  if (HEIGHT < 1) begin : g_height_check
    $error("HEIGHT must be at least 1");
  end

  typedef enum logic {IDLE, STREAM} state_t;

  state_t              state_q, state_d;
  logic [ROW_W-1:0]    row_q, src_row;
  logic                inv_q, gray_q, src_inv, src_gray;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [RC_W-1:0]     rc_d;
  logic [BUS_W-1:0]    src_beats [BEATS];
  logic [BUS_W-1:0]    src_beat, data_d;
  logic                load, last_d, sof_d, eof_d;
  logic                row_accept, out_xfer;

  function automatic logic [BIT_DEPTH-1:0] decode_pixel(input logic [BIT_DEPTH-1:0] raw,
                                                        input logic inv, input logic gray);
    logic [BIT_DEPTH-1:0] v, b;
    v = inv ? ~raw : raw;
    b = v;
    if (gray) begin
      for (int n = BIT_DEPTH - 2; n >= 0; n--) b[n] = b[n+1] ^ v[n];
    end
    return b;
  endfunction

  // A new row may only slip in while the last beat of the current one is leaving.
  assign ROW_READY  = !RESET && ((state_q == IDLE) ||
                                 (state_q == STREAM && OUT_LAST && OUT_READY));
  assign row_accept = ROW_VALID && ROW_READY;
  assign out_xfer   = OUT_VALID && OUT_READY;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    beat_d   = beat_q;
    rc_d     = ROW_COUNT;
    load     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (row_accept) begin
          state_d = STREAM;
          beat_d  = '0;
          load    = 1'b1;
        end
      end
      STREAM: begin
        if (out_xfer) begin
          if (OUT_LAST) begin
            rc_d = (ROW_COUNT == LAST_ROW) ? '0 : ROW_COUNT + RC_W'(1);
            if (row_accept) begin
              beat_d = '0;
              load   = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
            load   = 1'b1;
          end
        end
      end
    endcase

    // Beat 0 of a freshly accepted row comes straight from the inputs.
    src_row  = row_accept ? ROW_DATA  : row_q;
    src_inv  = row_accept ? INVERT_EN : inv_q;
    src_gray = row_accept ? GRAY_EN   : gray_q;
    for (int b = 0; b < BEATS; b++) src_beats[b] = src_row[b*BUS_W +: BUS_W];
    src_beat = src_beats[beat_d];
    for (int i = 0; i < P; i++) begin
      data_d[i*BIT_DEPTH +: BIT_DEPTH] =
        decode_pixel(src_beat[i*BIT_DEPTH +: BIT_DEPTH], src_inv, src_gray);
    end
    last_d = (beat_d == LAST_BEAT);
    sof_d  = (rc_d == '0) && (beat_d == '0);
    eof_d  = (rc_d == LAST_ROW) && last_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      ROW_COUNT <= '0;
      // NOTE: the row buffer is small and explicitly cleared so no stale pixels survive reset.
      row_q     <= '0;
      inv_q     <= 1'b0;
      gray_q    <= 1'b0;
      OUT_DATA  <= '0;
      OUT_VALID <= 1'b0;
      OUT_LAST  <= 1'b0;
      OUT_SOF   <= 1'b0;
      OUT_EOF   <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      ROW_COUNT <= rc_d;
      if (row_accept) begin
        row_q  <= ROW_DATA;
        inv_q  <= INVERT_EN;
        gray_q <= GRAY_EN;
      end
      if (load) begin
        OUT_DATA  <= data_d;
        OUT_VALID <= 1'b1;
        OUT_LAST  <= last_d;
        OUT_SOF   <= sof_d;
        OUT_EOF   <= eof_d;
      end else if (state_d == IDLE) begin
        OUT_VALID <= 1'b0;
        OUT_LAST  <= 1'b0;
        OUT_SOF   <= 1'b0;
        OUT_EOF   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_row_streamer.sv
// Directed bench for pixel_row_streamer (default parameters: 8-bit pixels, 4 per row,
// 2 per beat, 2 rows per frame); expected beats are hand-computed.
module tb_pixel_row_streamer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] ROW_DATA;
  logic        ROW_VALID;
  logic        ROW_READY;
  logic        INVERT_EN;
  logic        GRAY_EN;
  logic [15:0] OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        OUT_LAST;
  logic        OUT_SOF;
  logic        OUT_EOF;
  logic [1:0]  ROW_COUNT;

  int passed = 0;
  int total  = 0;

  pixel_row_streamer dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .ROW_DATA  (ROW_DATA),
    .ROW_VALID (ROW_VALID),
    .ROW_READY (ROW_READY),
    .INVERT_EN (INVERT_EN),
    .GRAY_EN   (GRAY_EN),
    .OUT_DATA  (OUT_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_LAST  (OUT_LAST),
    .OUT_SOF   (OUT_SOF),
    .OUT_EOF   (OUT_EOF),
    .ROW_COUNT (ROW_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Checks the registered beat outputs in one go.
  task automatic chk_beat(input string tag, input logic [15:0] data, input logic last,
                          input logic sof, input logic eof, input logic [1:0] rc);
    chk({tag, "_valid"}, 32'(OUT_VALID), 32'd1);
    chk({tag, "_data"},  32'(OUT_DATA),  32'(data));
    chk({tag, "_last"},  32'(OUT_LAST),  32'(last));
    chk({tag, "_sof"},   32'(OUT_SOF),   32'(sof));
    chk({tag, "_eof"},   32'(OUT_EOF),   32'(eof));
    chk({tag, "_rc"},    32'(ROW_COUNT), 32'(rc));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET = 1'b1; ROW_DATA = '0; ROW_VALID = 1'b0; INVERT_EN = 1'b0; GRAY_EN = 1'b0;
    OUT_READY = 1'b1;
    tick(); tick();
    // Reset state
    chk("rst_row_ready", 32'(ROW_READY), 32'd0);
    chk("rst_valid",     32'(OUT_VALID), 32'd0);
    chk("rst_data",      32'(OUT_DATA),  32'd0);
    chk("rst_rc",        32'(ROW_COUNT), 32'd0);
    RESET = 1'b0;
    #1;
    chk("idle_row_ready", 32'(ROW_READY), 32'd1);

    // 1: invert + Gray decode
    ROW_DATA = 32'h3FFF7FF0; INVERT_EN = 1'b1; GRAY_EN = 1'b1; ROW_VALID = 1'b1;
    tick();
    ROW_VALID = 1'b0;
    chk_beat("t1_b0", 16'hFF0A, 1'b0, 1'b1, 1'b0, 2'd0);
    chk("t1_b0_row_ready", 32'(ROW_READY), 32'd0);
    tick();
    chk_beat("t1_b1", 16'h8000, 1'b1, 1'b0, 1'b0, 2'd0);
    chk("t1_b1_row_ready", 32'(ROW_READY), 32'd1);
    tick();
    chk("t1_idle_valid", 32'(OUT_VALID), 32'd0);
    chk("t1_idle_rc",    32'(ROW_COUNT), 32'd1);

    // 2: pass-through, row 1 of the frame
    ROW_DATA = 32'h44332211; INVERT_EN = 1'b0; GRAY_EN = 1'b0; ROW_VALID = 1'b1;
    tick();
    ROW_VALID = 1'b0;
    chk_beat("t2_b0", 16'h2211, 1'b0, 1'b0, 1'b0, 2'd1);
    tick();
    chk_beat("t2_b1", 16'h4433, 1'b1, 1'b0, 1'b1, 2'd1);
    tick();
    chk("t2_idle_valid", 32'(OUT_VALID), 32'd0);
    chk("t2_idle_rc",    32'(ROW_COUNT), 32'd0);

    // 3: backpressure on beat 0 for three cycles
    ROW_DATA = 32'h0D0C0B0A; ROW_VALID = 1'b1; OUT_READY = 1'b0;
    tick();
    ROW_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_beat("t3_hold", 16'h0B0A, 1'b0, 1'b1, 1'b0, 2'd0);
      chk("t3_hold_row_ready", 32'(ROW_READY), 32'd0);
      if (i == 2) OUT_READY = 1'b1;
      tick();
    end
    chk_beat("t3_b1", 16'h0D0C, 1'b1, 1'b0, 1'b0, 2'd0);
    tick();
    chk("t3_idle_valid", 32'(OUT_VALID), 32'd0);

    // 4: back-to-back rows A, B, C from a fresh frame
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    ROW_DATA = 32'h04030201; ROW_VALID = 1'b1;
    tick();
    ROW_DATA = 32'h08070605;
    chk_beat("t4_a0", 16'h0201, 1'b0, 1'b1, 1'b0, 2'd0);
    tick();
    chk_beat("t4_a1", 16'h0403, 1'b1, 1'b0, 1'b0, 2'd0);
    chk("t4_a1_row_ready", 32'(ROW_READY), 32'd1);
    tick();
    ROW_DATA = 32'h0C0B0A09;
    chk_beat("t4_b0", 16'h0605, 1'b0, 1'b0, 1'b0, 2'd1);
    tick();
    chk_beat("t4_b1", 16'h0807, 1'b1, 1'b0, 1'b1, 2'd1);
    tick();
    ROW_VALID = 1'b0;
    chk_beat("t4_c0", 16'h0A09, 1'b0, 1'b1, 1'b0, 2'd0);
    tick();
    chk_beat("t4_c1", 16'h0C0B, 1'b1, 1'b0, 1'b0, 2'd0);
    tick();
    chk("t4_idle_valid", 32'(OUT_VALID), 32'd0);
    chk("t4_idle_rc",    32'(ROW_COUNT), 32'd1);

    // 5: reset while beat 0 of row 1 is pending
    ROW_DATA = 32'h11223344; ROW_VALID = 1'b1; OUT_READY = 1'b0;
    tick();
    ROW_VALID = 1'b0;
    chk_beat("t5_pend", 16'h3344, 1'b0, 1'b0, 1'b0, 2'd1);
    RESET = 1'b1;
    #1;
    chk("t5_rst_row_ready", 32'(ROW_READY), 32'd0);
    tick();
    chk("t5_rst_valid", 32'(OUT_VALID), 32'd0);
    chk("t5_rst_data",  32'(OUT_DATA),  32'd0);
    chk("t5_rst_rc",    32'(ROW_COUNT), 32'd0);
    RESET = 1'b0; OUT_READY = 1'b1;
    ROW_DATA = 32'h55667788; ROW_VALID = 1'b1;
    tick();
    ROW_VALID = 1'b0;
    chk_beat("t5_b0", 16'h7788, 1'b0, 1'b1, 1'b0, 2'd0);
    tick();
    chk_beat("t5_b1", 16'h5566, 1'b1, 1'b0, 1'b0, 2'd0);
    tick();

    // 6: mode latched at accept; toggling GRAY_EN mid-row has no effect
    ROW_DATA = 32'h00C000C0; INVERT_EN = 1'b0; GRAY_EN = 1'b1; ROW_VALID = 1'b1;
    tick();
    ROW_VALID = 1'b0; GRAY_EN = 1'b0;
    chk("t6_g1_b0", 32'(OUT_DATA), 32'h0080);
    tick();
    chk("t6_g1_b1", 32'(OUT_DATA), 32'h0080);
    tick();
    ROW_VALID = 1'b1;
    tick();
    ROW_VALID = 1'b0; GRAY_EN = 1'b1;
    chk("t6_g0_b0", 32'(OUT_DATA), 32'h00C0);
    tick();
    chk("t6_g0_b1", 32'(OUT_DATA), 32'h00C0);
    tick();
    chk("t6_idle_valid", 32'(OUT_VALID), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pixel_row_streamer.md
Name: pixel_row_streamer

Overview:
- Next-generation row readout bus for the digital pixel sensor.
- Captures one full row of pixel-memory data, then serialises it into OUTPUT_BUS_PIXEL_WIDTH-pixel beats on a valid/ready output stream.
- Per-row selectable un-inversion and Gray-to-binary decoding; row and frame counting with start/end-of-frame flags.
- Sits between the pixel array and the chip output interface, replacing separate read/write clocks with one clock and explicit handshakes.

Parameters:
- BIT_DEPTH, 8, bits per pixel.
- WIDTH, 4, pixels per row; must be an integer multiple of OUTPUT_BUS_PIXEL_WIDTH (elaboration error otherwise).
- OUTPUT_BUS_PIXEL_WIDTH, 2, pixels per output beat (P). BEATS = WIDTH/P.
- HEIGHT, 2, rows per frame; must be >= 1.

Ports:
- CLK  in  1  single clock, rising edge.
- RESET  in  1  synchronous reset, active-high.
- ROW_DATA  in  WIDTH*BIT_DEPTH  row from pixel memory; pixel j at bits [(j+1)*BIT_DEPTH-1 : j*BIT_DEPTH].
- ROW_VALID  in  1  ROW_DATA is valid.
- ROW_READY  out  1  block accepts a row this cycle (handshake = ROW_VALID & ROW_READY).
- INVERT_EN  in  1  invert raw pixel bits before decoding; sampled at row accept.
- GRAY_EN  in  1  apply Gray-to-binary decode; sampled at row accept.
- OUT_DATA  out  P*BIT_DEPTH  current beat.
- OUT_VALID  out  1  OUT_DATA valid.
- OUT_READY  in  1  downstream accepts beat (transfer = OUT_VALID & OUT_READY).
- OUT_LAST  out  1  current beat is last beat of its row.
- OUT_SOF  out  1  current beat is beat 0 of row 0 of a frame.
- OUT_EOF  out  1  current beat is last beat of row HEIGHT-1.
- ROW_COUNT  out  $clog2(HEIGHT+1)  index of row currently being output.

Behaviour:
- Reset, while RESET=1 and on the cycle after: OUT_VALID=0, OUT_DATA=0, OUT_LAST=0, OUT_SOF=0, OUT_EOF=0, ROW_COUNT=0, beat index=0, state IDLE, row buffer cleared. ROW_READY=0 while RESET=1.
- Reset mid-row discards the remaining beats; the next accepted row is row 0 of a new frame.
- States:
  - IDLE: ROW_READY=1, OUT_VALID=0. On a row handshake, go to STREAM.
  - STREAM: OUT_VALID=1.
- Row accept:
  - Capture ROW_DATA, INVERT_EN and GRAY_EN into the buffer and a mode register.
  - Beat 0 appears on OUT_DATA at the next edge (latency 1 cycle from handshake to OUT_VALID).
- Beat k contents: pixels k*P .. k*P+P-1, with pixel k*P+i at OUT_DATA[(i+1)*BIT_DEPTH-1 : i*BIT_DEPTH].
- Per-pixel transform:
  - v = INVERT_EN ? ~raw : raw.
  - If GRAY_EN: MSB passes through; bit n = bin[n+1] ^ v[n] for n = BIT_DEPTH-2 down to 0.
  - Otherwise the output is v.
  - Mode is fixed for the whole row.
- Output register behaviour:
  - OUT_DATA and the flags are registered.
  - They hold stable while OUT_VALID=1 and OUT_READY=0.
  - On a transfer they advance to beat k+1 at the next edge.
- Last beat transfer:
  - ROW_READY=1 in STREAM only while OUT_LAST & OUT_READY (combinational).
  - If a row handshake occurs in that cycle, beat 0 of the new row follows with no bubble (back-to-back rows, full throughput of one beat per cycle).
  - Otherwise go to IDLE with OUT_VALID=0.
- Row accepts outside IDLE or the last-beat transfer are impossible: ROW_READY=0.
- ROW_COUNT:
  - Increments on each last-beat transfer.
  - Wraps to 0 after HEIGHT-1.
  - OUT_SOF = (ROW_COUNT==0 & beat 0).
  - OUT_EOF = (ROW_COUNT==HEIGHT-1 & OUT_LAST).
- BEATS=1 case: every beat asserts OUT_LAST; HEIGHT=1 case: each row asserts both OUT_SOF and OUT_EOF.
- Changes to INVERT_EN or GRAY_EN mid-row have no effect until the next accept.

Test Plan:
1. Defaults. INVERT_EN=1, GRAY_EN=1, ROW_DATA=0x3FFF7FF0, OUT_READY=1 -> ROW_READY=1; beat0 OUT_DATA=0xFF0A with OUT_SOF=1; beat1 0x8000 with OUT_LAST=1; then IDLE.
2. INVERT_EN=0, GRAY_EN=0, ROW_DATA=0x44332211 -> beats 0x2211 then 0x4433, unmodified.
3. Backpressure: OUT_READY=0 for 3 cycles during beat0 -> OUT_DATA, OUT_VALID and flags held for 3 cycles, ROW_READY=0 throughout; beat1 follows one cycle after OUT_READY rises.
4. Back-to-back: row A then row B with ROW_VALID held and OUT_READY=1 -> 4 consecutive beats with no OUT_VALID gap. Row B beat1 has OUT_EOF=1 and ROW_COUNT=1. A third row gets OUT_SOF=1 and ROW_COUNT=0.
5. Reset mid-row: RESET for 1 cycle while beat0 is pending -> OUT_VALID=0 the next cycle. The next row starts with OUT_SOF=1 and ROW_COUNT=0.
6. Mode latching: GRAY_EN toggled after accept with raw 0x00C0 (no invert) -> beat uses the mode sampled at accept: 0x0080 if sampled as 1, 0x00C0 if sampled as 0.
